// File: rtl/mmio_hub.sv
// rtl/mmio_hub.sv - relocatable MMIO register window with periodic timer,
// multiplexed hex display scan, debounced buttons and a combined irq.
module mmio_hub #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000FF00,
  parameter int          NUM_DIGITS   = 4,
  parameter logic [31:0] PERIOD_RST   = 32'd50_000_000,
  parameter int          SCAN_DIV     = 50_000,
  parameter int          NUM_BTN      = 4,
  parameter int          DEBOUNCE_CYC = 500_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           adr,
  input  logic [31:0]           writedata,
  input  logic                  memwrite,
  input  logic [NUM_BTN-1:0]    btn_in,
  output logic [31:0]           io_data,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  irq
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);

  localparam logic [31:0] OFF_DISPLAY = 32'd0;
  localparam logic [31:0] OFF_STATUS  = 32'd1;
  localparam logic [31:0] OFF_PERIOD  = 32'd2;
  localparam logic [31:0] OFF_CTRL    = 32'd3;
  localparam logic [31:0] OFF_COUNT   = 32'd4;
  localparam logic [31:0] OFF_BSTATE  = 32'd5;
  localparam logic [31:0] OFF_BEDGE   = 32'd6;
  localparam logic [31:0] OFF_SEG     = 32'd8;
  localparam logic [31:0] OFF_AN      = 32'd9;

  logic [DW-1:0]         r_display;
  logic [31:0]           r_period;
  logic [31:0]           r_count;
  logic                  r_tmr_en;
  logic                  r_tick_ie;
  logic                  r_btn_ie;
  logic                  r_blank_lz;
  logic                  r_tick_flag;
  logic                  r_tick_toggle;
  logic [NUM_BTN-1:0]    r_sync1;
  logic [NUM_BTN-1:0]    r_sync2;
  logic [NUM_BTN-1:0]    r_btn_state;
  logic [NUM_BTN-1:0]    r_btn_edge;
  logic [DB_W-1:0]       r_db_cnt [NUM_BTN];
  logic [SCAN_W-1:0]     r_scan_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_irq;

  // Offset wraps modulo 2^32, so only exact BASE_ADDR+k matches decode.
  logic [31:0] w_off;
  logic        w_wr_display, w_wr_status, w_wr_period, w_wr_ctrl, w_wr_bedge;

  assign w_off        = adr - BASE_ADDR;
  assign w_wr_display = memwrite && (w_off == OFF_DISPLAY);
  assign w_wr_status  = memwrite && (w_off == OFF_STATUS);
  assign w_wr_period  = memwrite && (w_off == OFF_PERIOD);
  assign w_wr_ctrl    = memwrite && (w_off == OFF_CTRL);
  assign w_wr_bedge   = memwrite && (w_off == OFF_BEDGE);

  logic w_tmr_clear;
  logic w_tick;

  assign w_tmr_clear = w_wr_period || (w_wr_ctrl && writedata[0] && !r_tmr_en);
  assign w_tick      = !w_tmr_clear && r_tmr_en && (r_period != 32'd0) &&
                       (r_count >= r_period - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_display     <= '0;
      r_period      <= PERIOD_RST;
      r_count       <= 32'd0;
      r_tmr_en      <= 1'b0;
      r_tick_ie     <= 1'b0;
      r_btn_ie      <= 1'b0;
      r_blank_lz    <= 1'b0;
      r_tick_flag   <= 1'b0;
      r_tick_toggle <= 1'b0;
    end else begin
      if (w_wr_display) r_display <= writedata[DW-1:0];
      if (w_wr_period)  r_period  <= writedata;
      if (w_wr_ctrl) begin
        r_tmr_en   <= writedata[0];
        r_tick_ie  <= writedata[2];
        r_btn_ie   <= writedata[3];
        r_blank_lz <= writedata[4];
      end
      if (w_tmr_clear || w_tick) begin
        r_count <= 32'd0;
      end else if (r_tmr_en && (r_period != 32'd0)) begin
        r_count <= r_count + 32'd1;
      end
      // A tick on the same edge as the W1C keeps the flag set.
      if (w_tick) begin
        r_tick_flag <= 1'b1;
      end else if (w_wr_status && writedata[0]) begin
        r_tick_flag <= 1'b0;
      end
      if (w_tick) r_tick_toggle <= !r_tick_toggle;
    end
  end

  logic [NUM_BTN-1:0] w_btn_accept;
  logic [NUM_BTN-1:0] w_edge_clr;

  always_comb begin
    w_btn_accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_btn_accept[i] = (r_sync2[i] != r_btn_state[i]) && (r_db_cnt[i] == DB_LAST);
    end
  end

  assign w_edge_clr = w_wr_bedge ? writedata[NUM_BTN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_btn_state <= '0;
      r_btn_edge  <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1     <= btn_in;
      r_sync2     <= r_sync1;
      r_btn_state <= r_btn_state ^ w_btn_accept;
      // Accepting with sync2=1 is a 0->1 transition of the debounced level.
      r_btn_edge  <= (r_btn_edge & ~w_edge_clr) | (w_btn_accept & r_sync2);
      for (int i = 0; i < NUM_BTN; i++) begin
        if ((r_sync2[i] == r_btn_state[i]) || w_btn_accept[i]) begin
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic                  w_scan_wrap;
  logic [IDX_W-1:0]      w_idx_adv;
  logic [DW-1:0]         w_shifted;
  logic                  w_blank;
  logic [7:0]            w_seg_next;
  logic [NUM_DIGITS-1:0] w_an_next;

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_idx_adv   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
  // Nibbles at and above the digit being zero means it sits above the MS digit.
  assign w_shifted   = r_display >> {w_idx_adv, 2'b00};
  assign w_blank     = r_blank_lz && (w_idx_adv != '0) && (w_shifted == '0);
  assign w_seg_next  = w_blank ? 8'hFF : {1'b1, hex7(w_shifted[3:0])};
  assign w_an_next   = ~(NUM_DIGITS'(1) << w_idx_adv);

  // Segment data is captured only at slot boundaries, so writes never
  // disturb the digit currently being shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_an       <= ~NUM_DIGITS'(1);
      r_seg      <= 8'hC0;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_idx      <= w_idx_adv;
      r_an       <= w_an_next;
      r_seg      <= w_seg_next;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (r_tick_flag && r_tick_ie) || ((|r_btn_edge) && r_btn_ie);
    end
  end

  always_comb begin
    io_data = 32'd0;
    case (w_off)
      OFF_DISPLAY: io_data = 32'(r_display);
      OFF_STATUS:  io_data = {30'd0, r_tick_toggle, r_tick_flag};
      OFF_PERIOD:  io_data = r_period;
      OFF_CTRL:    io_data = {27'd0, r_blank_lz, r_btn_ie, r_tick_ie, 1'b0, r_tmr_en};
      OFF_COUNT:   io_data = r_count;
      OFF_BSTATE:  io_data = 32'(r_btn_state);
      OFF_BEDGE:   io_data = 32'(r_btn_edge);
      OFF_SEG:     io_data = 32'(r_seg);
      OFF_AN:      io_data = 32'(r_an);
      default:     io_data = 32'd0;
    endcase
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign irq = r_irq;

endmodule

// File: tb/tb_mmio_hub.sv
// tb/tb_mmio_hub.sv - directed self-checking bench for mmio_hub
`timescale 1ns/1ps
module tb_mmio_hub;

  localparam logic [31:0] BASE = 32'h0000FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [3:0]  btn_in;
  logic [31:0] io_data;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_rst [0:10];

  mmio_hub #(
    .BASE_ADDR(BASE), .NUM_DIGITS(4), .PERIOD_RST(32'd5),
    .SCAN_DIV(2), .NUM_BTN(4), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
    .memwrite(memwrite), .btn_in(btn_in), .io_data(io_data),
    .seg(seg), .an(an), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rchk(input string tag, input int off, input logic [31:0] exp);
    adr = BASE + 32'(off);
    #1;
    chk(tag, io_data, exp);
  endtask

  task automatic wr_abs(input logic [31:0] a, input logic [31:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    wr_abs(BASE + 32'(off), d);
  endtask

  task automatic scan_chk(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [3:0] seen;
    logic [7:0] exp_s;
    seen = 4'h0;
    for (int i = 0; i < 8; i++) begin
      case (an)
        4'hE: begin exp_s = e0; seen[0] = 1'b1; end
        4'hD: begin exp_s = e1; seen[1] = 1'b1; end
        4'hB: begin exp_s = e2; seen[2] = 1'b1; end
        4'h7: begin exp_s = e3; seen[3] = 1'b1; end
        default: exp_s = 8'h00;
      endcase
      chk($sformatf("%s_seg_an%h", tag, an), 32'(seg), 32'(exp_s));
      cyc(1);
    end
    chk({tag, "_digits_seen"}, 32'(seen), 32'hF);
  endtask

  initial begin
    exp_rst = '{32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                32'hC0, 32'hE, 32'd0};
    reset = 1'b1; memwrite = 1'b0; adr = 32'd0; writedata = 32'd0; btn_in = 4'h0;

    // reset state, read while reset is still held
    cyc(2);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'hC0);
    for (int k = 0; k <= 10; k++) rchk($sformatf("rst_off%0d", k), k, exp_rst[k]);
    cyc(1);
    reset = 1'b0;

    // timer with P=5
    wr(3, 32'h5);
    rchk("tmr_cnt_w0", 4, 32'd0);
    rchk("tmr_status_w0", 1, 32'd0);
    cyc(4);
    rchk("tmr_cnt_w4", 4, 32'd4);
    rchk("tmr_flag_pre", 1, 32'd0);
    cyc(1);
    rchk("tmr_flag_set", 1, 32'd3);
    rchk("tmr_cnt_wrap", 4, 32'd0);
    chk("irq_pre", 32'(irq), 32'd0);
    cyc(1);
    chk("irq_tick", 32'(irq), 32'd1);
    wr(1, 32'h1);
    rchk("flag_w1c", 1, 32'd2);
    chk("irq_hold", 32'(irq), 32'd1);
    cyc(1);
    chk("irq_drop", 32'(irq), 32'd0);
    cyc(1);
    rchk("cnt_pre_tick", 4, 32'd4);
    wr(1, 32'h1);
    rchk("flag_set_wins", 1, 32'd1);
    wr(1, 32'h1);
    rchk("flag_clr2", 1, 32'd0);
    wr(2, 32'h0);
    cyc(8);
    rchk("p0_cnt", 4, 32'd0);
    rchk("p0_status", 1, 32'd0);
    rchk("p0_period", 2, 32'd0);

    // register access boundaries
    wr(3, 32'h8);
    rchk("ctrl_rd", 3, 32'h8);
    wr(5, 32'hF);
    rchk("ro_write_ignored", 5, 32'd0);
    wr_abs(BASE + 32'h100, 32'h1234);
    rchk("oow_write_ignored", 0, 32'd0);
    rchk("unmapped_off7", 7, 32'd0);

    // button debounce with bounce on btn_in[0]
    btn_in = 4'h1; cyc(1);
    btn_in = 4'h0; cyc(1);
    btn_in = 4'h1; cyc(1);
    btn_in = 4'h0; cyc(1);
    btn_in = 4'h1;
    cyc(5);
    rchk("btn_pre", 5, 32'd0);
    cyc(1);
    rchk("btn_state", 5, 32'd1);
    rchk("btn_edge", 6, 32'd1);
    chk("btn_irq_pre", 32'(irq), 32'd0);
    cyc(1);
    chk("btn_irq", 32'(irq), 32'd1);
    wr(6, 32'h1);
    rchk("edge_w1c", 6, 32'd0);
    rchk("btn_state_kept", 5, 32'd1);
    chk("irq_hold2", 32'(irq), 32'd1);
    cyc(1);
    chk("irq_drop2", 32'(irq), 32'd0);
    btn_in = 4'h0;
    cyc(6);
    rchk("btn_release", 5, 32'd0);
    rchk("edge_no_fall", 6, 32'd0);

    // display scan with and without leading-zero blanking
    wr(0, 32'h00A3);
    wr(3, 32'h10);
    cyc(10);
    scan_chk("lz1", 8'hB0, 8'h88, 8'hFF, 8'hFF);
    wr(3, 32'h0);
    cyc(10);
    scan_chk("lz0", 8'hB0, 8'h88, 8'hC0, 8'hC0);

    // mid-operation reset with timer running and debounce in flight
    wr(2, 32'd100);
    wr(3, 32'h1D);
    wr(0, 32'h1234);
    btn_in = 4'h3;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    chk("mrst_irq", 32'(irq), 32'd0);
    chk("mrst_an", 32'(an), 32'hE);
    chk("mrst_seg", 32'(seg), 32'hC0);
    for (int k = 0; k <= 9; k++) rchk($sformatf("mrst_off%0d", k), k, exp_rst[k]);
    cyc(1);
    reset = 1'b0;
    cyc(5);
    rchk("db_restart_pre", 5, 32'd0);
    cyc(1);
    rchk("db_restart", 5, 32'd3);
    rchk("db_restart_edge", 6, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
